// File: rtl/ai_sched_pkg.sv
// rtl/ai_sched_pkg.sv - shared types, constants and direction bias table for the AI tank scheduler
package ai_sched_pkg;

  typedef enum logic [1:0] {WAIT, ARB, DRAW, COMMIT} state_t;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Down gets 11 of 32 codes so AI tanks drift toward the player's base.
  function automatic logic [1:0] dir_from_rnd(input logic [4:0] d);
    if (d <= 5'd10)      return DIR_DOWN;
    else if (d <= 5'd17) return DIR_LEFT;
    else if (d <= 5'd24) return DIR_RIGHT;
    else                 return DIR_UP;
  endfunction

endpackage

// File: rtl/ai_tank_scheduler_if.sv
// rtl/ai_tank_scheduler_if.sv - decision output bus from the scheduler to tank movement/bullet logic
interface ai_tank_scheduler_if #(parameter int NUM_TANKS = 4);

  localparam int IDX_W = $clog2(NUM_TANKS);

  logic [4*NUM_TANKS-1:0] AI_tank_control;
  logic [NUM_TANKS-1:0]   decision_valid;
  logic [IDX_W-1:0]       grant_idx;

  modport master (output AI_tank_control, decision_valid, grant_idx);
  modport slave  (input  AI_tank_control, decision_valid, grant_idx);

endinterface

// File: rtl/ai_tank_scheduler_lfsr.sv
// rtl/ai_tank_scheduler_lfsr.sv - 16-bit Galois LFSR shared by all AI tanks
module ai_lfsr16
  import ai_sched_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      q <= SEED;
    end else if (en) begin
      // Zero is a lock-up state for a Galois LFSR; recover from it.
      if (q == 16'h0000)
        q <= SEED;
      else if (q[0])
        q <= (q >> 1) ^ LFSR_TAPS;
      else
        q <= q >> 1;
    end
  end

endmodule

// File: rtl/ai_tank_scheduler.sv
// rtl/ai_tank_scheduler.sv - round-robin/urgent decision scheduler for AI tanks; AI_BLOCKED_REDECIDE_EN enables the blocked-tank urgent path
module ai_tank_scheduler
  import ai_sched_pkg::*;
#(
  parameter int          NUM_TANKS = 4,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [31:0]          interval,
  input  logic                 freeze,
  input  logic [NUM_TANKS-1:0] tank_alive,
  input  logic [NUM_TANKS-1:0] blocked_req,
  ai_tank_scheduler_if.master  dec
);

  localparam int IW = $clog2(NUM_TANKS);

  state_t                 state;
  logic [31:0]            tick_cnt;
  logic                   sched_pend;
  logic [NUM_TANKS-1:0]   urgent_pend;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          grant;
  logic                   urgent_svc;
  logic [15:0]            r;
  logic [15:0]            lfsr_q;
  logic [4*NUM_TANKS-1:0] ctl;
  logic [NUM_TANKS-1:0]   dv;

  logic                   urg_hit, alive_hit;
  logic [IW-1:0]          urg_idx, alive_idx, cand;
  logic [1:0]             drawn_dir, new_dir;
  logic                   new_move;
  logic [3:0]             new_word;

  wire unused_r = ^r[15:8];
`ifndef AI_BLOCKED_REDECIDE_EN
  wire unused_blocked = ^blocked_req;
`endif

  ai_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .en      (~freeze),
    .q       (lfsr_q)
  );

  // Scan from the pointer backwards so the nearest candidate at/after rr_ptr wins.
  always_comb begin
    urg_hit   = 1'b0;
    urg_idx   = rr_ptr;
    alive_hit = 1'b0;
    alive_idx = rr_ptr;
    cand      = '0;
    for (int k = NUM_TANKS - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_TANKS);
      if (urgent_pend[cand]) begin
        urg_hit = 1'b1;
        urg_idx = cand;
      end
      if (tank_alive[cand]) begin
        alive_hit = 1'b1;
        alive_idx = cand;
      end
    end
  end

  always_comb begin
    drawn_dir = dir_from_rnd(r[4:0]);
    new_move  = r[6] | r[7];
    new_dir   = drawn_dir;
`ifdef AI_BLOCKED_REDECIDE_EN
    // A blocked tank must move, and never retry the heading it is stuck on.
    if (urgent_svc) begin
      new_move = 1'b1;
      if (drawn_dir == ctl[4*grant +: 2])
        new_dir = drawn_dir + 2'd1;
    end
`endif
    new_word = {r[5], new_move, new_dir};
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= WAIT;
      tick_cnt    <= '0;
      sched_pend  <= 1'b0;
      urgent_pend <= '0;
      rr_ptr      <= '0;
      grant       <= '0;
      urgent_svc  <= 1'b0;
      r           <= '0;
      ctl         <= '0;
      dv          <= '0;
    end else begin
      dv <= '0;
      if (!freeze) begin
        case (state)
          WAIT: begin
            if ((|urgent_pend) || sched_pend)
              state <= ARB;
          end
          ARB: begin
            if (urg_hit) begin
              grant      <= urg_idx;
              urgent_svc <= 1'b1;
              state      <= DRAW;
            end else begin
              sched_pend <= 1'b0;
              if (alive_hit && sched_pend) begin
                grant      <= alive_idx;
                urgent_svc <= 1'b0;
                state      <= DRAW;
              end else begin
                state <= WAIT;
              end
            end
          end
          DRAW: begin
            if (!tank_alive[grant]) begin
              state <= WAIT;
            end else begin
              r     <= lfsr_q;
              state <= COMMIT;
            end
          end
          COMMIT: begin
            state <= WAIT;
            if (tank_alive[grant]) begin
              ctl[4*grant +: 4]  <= new_word;
              dv[grant]          <= 1'b1;
              urgent_pend[grant] <= 1'b0;
              if (!urgent_svc)
                rr_ptr <= (grant == IW'(NUM_TANKS - 1)) ? '0 : grant + 1'b1;
            end
          end
          default: state <= WAIT;
        endcase

        // Tick after the FSM so a tick coinciding with the ARB clear is kept.
        if (tick_cnt == interval) begin
          tick_cnt   <= '0;
          sched_pend <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 32'd1;
        end

        for (int i = 0; i < NUM_TANKS; i++) begin
          if (!tank_alive[i])
            urgent_pend[i] <= 1'b0;
`ifdef AI_BLOCKED_REDECIDE_EN
          if (blocked_req[i] && tank_alive[i])
            urgent_pend[i] <= 1'b1;
`endif
        end
      end

      for (int i = 0; i < NUM_TANKS; i++) begin
        if (!tank_alive[i])
          ctl[4*i +: 4] <= '0;
      end
    end
  end

  assign dec.AI_tank_control = ctl;
  assign dec.decision_valid  = dv;
  assign dec.grant_idx       = grant;

endmodule
